// File: rtl/lane_switch_pkg.sv
// Shared types for the lane switch: operand-merge modes, resolved patterns
// and the sign-steered pattern resolver.
package lane_switch_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO      = 2'b00,
        MODE_FORCE_ILV = 2'b01,
        MODE_FORCE_REV = 2'b10,
        MODE_PASS      = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        PAT_ILV  = 2'b00,
        PAT_REV  = 2'b01,
        PAT_PASS = 2'b10
    } pat_e;

    // AUTO steers on operand signs: matching signs reverse, differing signs interleave.
    function automatic pat_e resolve_pat(input mode_e mode, input logic sign_x, input logic sign_y);
        pat_e pat;
        case (mode)
            MODE_FORCE_ILV: pat = PAT_ILV;
            MODE_FORCE_REV: pat = PAT_REV;
            MODE_PASS:      pat = PAT_PASS;
            default:        pat = (sign_x == sign_y) ? PAT_REV : PAT_ILV;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/lane_permute.sv
// Lane merge of two operands into one double-width word (ILV, REV or PASS).
// Purely combinational; no handshake.
module lane_permute
    import lane_switch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 2
) (
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   y,
    input  pat_e                pat,
    output logic [2*DATA_W-1:0] o
);

    localparam int LW = DATA_W / LANES;

    logic [2*DATA_W-1:0] ilv;
    logic [2*DATA_W-1:0] rev;

    // Slots are numbered from the LSB in units of LW bits.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign ilv[(2*k+1)*LW +: LW]           = x[k*LW +: LW];
        assign ilv[(2*k)*LW   +: LW]           = y[k*LW +: LW];
        assign rev[(2*(LANES-1-k)+1)*LW +: LW] = y[k*LW +: LW];
        assign rev[(2*(LANES-1-k))*LW   +: LW] = x[k*LW +: LW];
    end

    always_comb begin
        case (pat)
            PAT_ILV: o = ilv;
            PAT_REV: o = rev;
            default: o = {x, y};
        endcase
    end

endmodule

// File: rtl/lane_switch_pipe.sv
// Two-stage valid/ready lane switch with a saturating REV-word counter; 2-edge latency.
// Stalls hold both stages; in_ready drops only when s1 and s2 are both full and blocked.
module lane_switch_pipe
    import lane_switch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   y,
    input  logic [1:0]          mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] o,
    output logic                out_rev,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    rev_cnt
);

    if ((DATA_W % LANES) != 0 || LANES < 2) begin : g_param_check
        $error("lane_switch_pipe: DATA_W must be a multiple of LANES and LANES must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_x;
    logic [DATA_W-1:0]   s1_y;
    mode_e               s1_mode;
    pat_e                s1_pat;
    logic                adv2;
    logic                accept;
    logic                rev_hs;
    logic [2*DATA_W-1:0] perm_o;

    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign accept   = in_valid && in_ready;
    assign rev_hs   = out_valid && out_ready && out_rev;

    assign s1_pat = resolve_pat(s1_mode, s1_x[DATA_W-1], s1_y[DATA_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= MODE_AUTO;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_x     <= x;
            s1_y     <= y;
            s1_mode  <= mode_e'(mode);
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    lane_permute #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_permute (
        .x   (s1_x),
        .y   (s1_y),
        .pat (s1_pat),
        .o   (perm_o)
    );

    // out_valid only clears on a handshake that has no s1 word queued behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            out_rev   <= 1'b0;
        end else if (adv2) begin
            out_valid <= 1'b1;
            o         <= perm_o;
            out_rev   <= (s1_pat == PAT_REV);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_cnt <= '0;
        end else if (cnt_clr) begin
            rev_cnt <= '0;
        end else if (rev_hs && (rev_cnt != CNT_MAX)) begin
            rev_cnt <= rev_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_lane_switch_pipe.sv
// Bench for lane_switch_pipe: directed vectors on an 8b/2-lane/3b-counter instance,
// directed plus randomized scoreboard traffic on a 16b/4-lane instance.
module tb_lane_switch_pipe;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, LANES=2, CNT_W=3
    logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_rev, a_cnt_clr;
    logic [7:0]  a_x, a_y;
    logic [1:0]  a_mode;
    logic [15:0] a_o;
    logic [2:0]  a_rev_cnt;

    // Instance B: DATA_W=16, LANES=4, CNT_W=16
    logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_rev, b_cnt_clr;
    logic [15:0] b_x, b_y;
    logic [1:0]  b_mode;
    logic [31:0] b_o;
    logic [15:0] b_rev_cnt;

    lane_switch_pipe #(.DATA_W(8), .LANES(2), .CNT_W(3)) dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x         (a_x),
        .y         (a_y),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .o         (a_o),
        .out_rev   (a_out_rev),
        .cnt_clr   (a_cnt_clr),
        .rev_cnt   (a_rev_cnt)
    );

    lane_switch_pipe #(.DATA_W(16), .LANES(4), .CNT_W(16)) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x         (b_x),
        .y         (b_y),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .o         (b_o),
        .out_rev   (b_out_rev),
        .cnt_clr   (b_cnt_clr),
        .rev_cnt   (b_rev_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference merge built from lane arithmetic; returns {rev, o}.
    function automatic logic [32:0] ref_merge(input int dw, input int nl,
                                              input logic [15:0] xv, input logic [15:0] yv,
                                              input logic [1:0] md);
        int          lw;
        int          mask;
        int          xl;
        int          yl;
        int          kind;
        logic [31:0] r;
        lw   = dw / nl;
        mask = (1 << lw) - 1;
        r    = '0;
        case (md)
            2'd1:    kind = 0;
            2'd2:    kind = 1;
            2'd3:    kind = 2;
            default: kind = (xv[dw-1] == yv[dw-1]) ? 1 : 0;
        endcase
        if (kind == 2) begin
            r = (32'(xv) << dw) | 32'(yv);
        end else begin
            for (int k = 0; k < nl; k++) begin
                if (kind == 0) begin
                    xl = (int'(xv) >> (k * lw)) & mask;
                    yl = (int'(yv) >> (k * lw)) & mask;
                    r  = r | (32'(xl) << ((2 * k + 1) * lw)) | (32'(yl) << (2 * k * lw));
                end else begin
                    // Reading the REV word from the LSB end walks the lanes top-down.
                    xl = (int'(xv) >> ((nl - 1 - k) * lw)) & mask;
                    yl = (int'(yv) >> ((nl - 1 - k) * lw)) & mask;
                    r  = r | (32'(xl) << (2 * k * lw)) | (32'(yl) << ((2 * k + 1) * lw));
                end
            end
        end
        return {(kind == 1), r};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_one(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [1:0] md, input logic [15:0] eo, input logic er,
                         input logic clr);
        a_x = xv; a_y = yv; a_mode = md; a_in_valid = 1'b1; a_out_ready = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        check_eq({tag, "_s1_only"}, a_out_valid, 1'b0);
        cyc();
        check_eq({tag, "_valid"}, a_out_valid, 1'b1);
        check_eq({tag, "_o"}, a_o, eo);
        check_eq({tag, "_rev"}, a_out_rev, er);
        a_cnt_clr = clr;
        cyc();
        a_cnt_clr = 1'b0;
        check_eq({tag, "_drop"}, a_out_valid, 1'b0);
    endtask

    logic [32:0] q[$];
    logic [32:0] exp_w;
    int          sent;
    int          cyc_n;
    int          b_rev_exp;
    int          in_low_seen;
    logic        stall_prev;
    logic [31:0] held_o;
    logic        held_rev;
    localparam int NWORDS = 200;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_cnt_clr = 1'b0;
        a_x = '0; a_y = '0; a_mode = '0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_cnt_clr = 1'b0;
        b_x = '0; b_y = '0; b_mode = '0;
        #3;
        check_eq("rst_a_out_valid", a_out_valid, 1'b0);
        check_eq("rst_a_o", a_o, 16'h0);
        check_eq("rst_a_out_rev", a_out_rev, 1'b0);
        check_eq("rst_a_rev_cnt", a_rev_cnt, 3'd0);
        check_eq("rst_b_out_valid", b_out_valid, 1'b0);
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        cyc();
        check_eq("rst_a_in_ready", a_in_ready, 1'b1);
        check_eq("rst_b_in_ready", b_in_ready, 1'b1);

        // Sign-steered AUTO on the 8-bit instance
        a_one("t1", 8'h00, 8'hFF, 2'd0, 16'h0F0F, 1'b0, 1'b0);
        check_eq("t1_cnt", a_rev_cnt, 3'd0);
        a_one("t2", 8'h80, 8'hFF, 2'd0, 16'hF0F8, 1'b1, 1'b0);
        check_eq("t2_cnt", a_rev_cnt, 3'd1);

        // Eight more REV words back to back: counter saturates at 7
        a_x = 8'h80; a_y = 8'hFF; a_mode = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        repeat (8) cyc();
        a_in_valid = 1'b0;
        repeat (3) cyc();
        check_eq("t5_sat", a_rev_cnt, 3'd7);
        a_one("t5c", 8'h00, 8'hFF, 2'd2, 16'hF0F0, 1'b1, 1'b1);
        check_eq("t5_clr_wins", a_rev_cnt, 3'd0);

        // Reset with both stages full
        a_one("t6a", 8'h80, 8'hFF, 2'd0, 16'hF0F8, 1'b1, 1'b0);
        check_eq("t6_cnt_pre", a_rev_cnt, 3'd1);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_x = 8'hAB; a_y = 8'hCD; a_mode = 2'd1;
        cyc();
        cyc();
        check_eq("t6_full_in_ready", a_in_ready, 1'b0);
        check_eq("t6_full_valid", a_out_valid, 1'b1);
        #1;
        a_rst_n = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check_eq("t6_rst_valid", a_out_valid, 1'b0);
        check_eq("t6_rst_cnt", a_rev_cnt, 3'd0);
        @(negedge clk);
        a_rst_n = 1'b1;
        a_out_ready = 1'b1;
        cyc();
        check_eq("t6_no_ghost1", a_out_valid, 1'b0);
        cyc();
        check_eq("t6_no_ghost2", a_out_valid, 1'b0);
        a_one("t6b", 8'h12, 8'h34, 2'd1, 16'h1324, 1'b0, 1'b0);

        // 16-bit, 4-lane vectors at full rate
        b_out_ready = 1'b1;
        b_x = 16'h1234; b_y = 16'h5678; b_mode = 2'd0; b_in_valid = 1'b1;
        cyc();
        check_eq("t3_rdy0", b_in_ready, 1'b1);
        b_x = 16'h9234;
        cyc();
        check_eq("t3_o_rev", b_o, 32'h84736251);
        check_eq("t3_rev_flag", b_out_rev, 1'b1);
        check_eq("t3_rdy1", b_in_ready, 1'b1);
        b_mode = 2'd3;
        cyc();
        check_eq("t3_o_ilv", b_o, 32'h95263748);
        check_eq("t3_valid1", b_out_valid, 1'b1);
        b_in_valid = 1'b0;
        cyc();
        check_eq("t3_o_pass", b_o, 32'h92345678);
        cyc();
        check_eq("t3_drain", b_out_valid, 1'b0);
        b_rev_exp = 1;

        // Randomized traffic with a forced 5-cycle stall early on
        sent = 0; cyc_n = 0; stall_prev = 1'b0; in_low_seen = 0;
        held_o = '0; held_rev = 1'b0;
        while (!(sent == NWORDS && q.size() == 0) && cyc_n < 4000) begin
            b_out_ready = (cyc_n >= 20 && cyc_n < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            b_in_valid  = (sent < NWORDS) ? ($urandom_range(0, 4) != 0) : 1'b0;
            b_x         = 16'($urandom);
            b_y         = 16'($urandom);
            b_mode      = 2'($urandom_range(0, 3));
            #1;
            check_eq("b_in_ready", b_in_ready, (q.size() < 2) || b_out_ready);
            if (!b_in_ready) in_low_seen++;
            if (stall_prev) begin
                check_eq("b_hold_o", b_o, held_o);
                check_eq("b_hold_rev", b_out_rev, held_rev);
            end
            if (b_out_valid && b_out_ready) begin
                check_eq("b_q_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check_eq("b_o", b_o, exp_w[31:0]);
                    check_eq("b_out_rev", b_out_rev, exp_w[32]);
                    if (exp_w[32]) b_rev_exp++;
                end
            end
            stall_prev = b_out_valid && !b_out_ready;
            held_o     = b_o;
            held_rev   = b_out_rev;
            if (b_in_valid && b_in_ready) begin
                q.push_back(ref_merge(16, 4, b_x, b_y, b_mode));
                sent++;
            end
            cyc();
            cyc_n++;
        end
        b_in_valid = 1'b0;
        check_eq("b_all_sent", sent, NWORDS);
        check_eq("b_drained", q.size(), 0);
        check_eq("b_backpressure_seen", in_low_seen > 0, 1'b1);
        check_eq("b_rev_cnt", b_rev_cnt, 16'(b_rev_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
